// File: rtl/cal_position_seq.sv
// cal_position_seq: sequential acoustic-source locator for a 4-mic square array.
// Converts TDOA delays (mics 2/3/4 relative to mic 1) into source position
// (x, y, z) in mm. A single shared restoring divider and a bitwise integer
// square root are sequenced by a state machine with a fixed latency.
//
// Ports:
//   fast_clk                      clock, rising edge
//   rst                           synchronous active-high reset
//   ena                           start request, accepted only in IDLE
//   delay12/delay13/delay14       signed delays in sample ticks
//   busy                          high in every non-IDLE state
//   cal_end                       one-cycle pulse, results valid
//   x_position/y_position/z_position  signed mm, held until next cal_end
//   err                           0 ok, 1 degenerate, 2 bad R, 3 below plane
//
// Build option: define CAL_POS_Z_EN to include the z (ZSQ/SQRT) datapath.
// Without it z_position is 0, err 3 never occurs and latency is 3*POS_W+3.

module cal_position_seq #(
  parameter int unsigned DELAY_W = 8,
  parameter int unsigned POS_W   = 16,
  parameter int unsigned VEL     = 34,
  parameter int unsigned L       = 100
) (
  input  logic                      fast_clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic signed [DELAY_W-1:0] delay12,
  input  logic signed [DELAY_W-1:0] delay13,
  input  logic signed [DELAY_W-1:0] delay14,
  output logic                      busy,
  output logic                      cal_end,
  output logic signed [POS_W-1:0]   x_position,
  output logic signed [POS_W-1:0]   y_position,
  output logic signed [POS_W-1:0]   z_position,
  output logic [1:0]                err
);

  localparam int unsigned IW = 2*POS_W + 4;
  localparam int unsigned SW = 2*POS_W;
  localparam int unsigned CW = $clog2(POS_W + 1);
  localparam logic signed [IW-1:0] VEL_S   = IW'(VEL);
  localparam logic signed [IW-1:0] L2_S    = IW'(2*L);
  localparam logic signed [IW-1:0] LSQ_S   = IW'(L*L);
  localparam logic signed [IW-1:0] POS_MAX = (IW'(1) << (POS_W-1)) - IW'(1);
  localparam logic [CW-1:0]        LAST_CNT = CW'(POS_W-1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_DIV_R, S_CALC_XY, S_DIV_X, S_DIV_Y,
`ifdef CAL_POS_Z_EN
    S_ZSQ, S_SQRT,
`endif
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          last, iter, iter_div;

  logic signed [DELAY_W-1:0] dly2_q, dly3_q, dly4_q;
  logic signed [IW-1:0] d2_q, d4_q, r_q, x_q, ynum_q;
  logic [1:0]           err_q;

  // shared divider: magnitudes, shifted divisor, quotient, sign, overflow
  logic [IW-1:0]    div_rem_q, div_den_q;
  logic [POS_W-1:0] div_q_q;
  logic             div_neg_q, div_ovf_q;

  logic signed [IW-1:0] d2_c, d3_c, d4_c, rnum_c, rden_c, xnum_c, ynum_c;
  logic signed [IW-1:0] ld_num, ld_den, q_ext, div_out, y_fin;
  logic [IW-1:0]        ld_num_abs, ld_den_abs, ld_den_sh;
  logic                 div_ld, ld_ovf, div_sub;
  logic [POS_W-1:0]     q_nx, z_fin;

`ifdef CAL_POS_Z_EN
  logic signed [IW-1:0] y_q, zsq_c;
  logic [IW-1:0]        sq_val_q;
  logic [POS_W-1:0]     sq_res_q, sq_bit_q, sq_trial, sq_res_nx;
  logic [SW-1:0]        sq_trial_sq;
`endif

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (ena) state_d = S_LOAD;
      S_LOAD:    state_d = S_DIV_R;
      S_DIV_R:   if (last) state_d = S_CALC_XY;
      S_CALC_XY: state_d = S_DIV_X;
      S_DIV_X:   if (last) state_d = S_DIV_Y;
`ifdef CAL_POS_Z_EN
      S_DIV_Y:   if (last) state_d = S_ZSQ;
      S_ZSQ:     state_d = S_SQRT;
      S_SQRT:    if (last) state_d = S_DONE;
`else
      S_DIV_Y:   if (last) state_d = S_DONE;
`endif
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // datapath: equation terms, divider load mux and one divider/sqrt step
  always_comb begin
    last     = (cnt_q == LAST_CNT);
    iter_div = (state_q == S_DIV_R) || (state_q == S_DIV_X) || (state_q == S_DIV_Y);
`ifdef CAL_POS_Z_EN
    iter     = iter_div || (state_q == S_SQRT);
`else
    iter     = iter_div;
`endif

    d2_c   = VEL_S * IW'(dly2_q);
    d3_c   = VEL_S * IW'(dly3_q);
    d4_c   = VEL_S * IW'(dly4_q);
    rnum_c = d2_c*d2_c + d4_c*d4_c - d3_c*d3_c;
    rden_c = (d3_c - d2_c - d4_c) <<< 1;
    xnum_c = LSQ_S - ((r_q * d2_q) <<< 1) - d2_q*d2_q;
    ynum_c = LSQ_S - ((r_q * d4_q) <<< 1) - d4_q*d4_q;

    div_ld = 1'b0;
    ld_num = rnum_c;
    ld_den = rden_c;
    case (state_q)
      S_LOAD:    div_ld = 1'b1;
      S_CALC_XY: begin div_ld = 1'b1; ld_num = xnum_c; ld_den = L2_S; end
      S_DIV_X:   if (last) begin div_ld = 1'b1; ld_num = ynum_q; ld_den = L2_S; end
      default:   ;
    endcase
    ld_num_abs = ld_num[IW-1] ? -ld_num : ld_num;
    ld_den_abs = ld_den[IW-1] ? -ld_den : ld_den;
    ld_den_sh  = ld_den_abs << (POS_W-1);
    // quotient would not fit in POS_W-1 magnitude bits (also catches den = 0)
    ld_ovf     = (ld_num_abs >= ld_den_sh);

    div_sub = (div_rem_q >= div_den_q);
    q_nx    = {div_q_q[POS_W-2:0], div_sub};
    q_ext   = IW'(q_nx);
    if (div_ovf_q) div_out = div_neg_q ? -POS_MAX : POS_MAX;
    else           div_out = div_neg_q ? -q_ext : q_ext;

`ifdef CAL_POS_Z_EN
    zsq_c       = r_q*r_q - x_q*x_q - y_q*y_q;
    sq_trial    = sq_res_q | sq_bit_q;
    sq_trial_sq = SW'(sq_trial) * SW'(sq_trial);
    sq_res_nx   = (IW'(sq_trial_sq) <= sq_val_q) ? sq_trial : sq_res_q;
    y_fin       = y_q;
    z_fin       = sq_res_nx;
`else
    y_fin       = div_out;
    z_fin       = '0;
`endif
  end

  // state register, datapath registers and registered outputs
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dly2_q     <= '0;
      dly3_q     <= '0;
      dly4_q     <= '0;
      d2_q       <= '0;
      d4_q       <= '0;
      r_q        <= '0;
      x_q        <= '0;
      ynum_q     <= '0;
      err_q      <= '0;
      div_rem_q  <= '0;
      div_den_q  <= '0;
      div_q_q    <= '0;
      div_neg_q  <= 1'b0;
      div_ovf_q  <= 1'b0;
`ifdef CAL_POS_Z_EN
      y_q        <= '0;
      sq_val_q   <= '0;
      sq_res_q   <= '0;
      sq_bit_q   <= '0;
`endif
      busy       <= 1'b0;
      cal_end    <= 1'b0;
      x_position <= '0;
      y_position <= '0;
      z_position <= '0;
      err        <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (iter && !last) ? cnt_q + CW'(1) : '0;
      busy    <= (state_d != S_IDLE);
      cal_end <= (state_d == S_DONE);

      if (state_q == S_IDLE && ena) begin
        dly2_q <= delay12;
        dly3_q <= delay13;
        dly4_q <= delay14;
      end

      if (state_q == S_LOAD) begin
        d2_q  <= d2_c;
        d4_q  <= d4_c;
        r_q   <= '0;
        err_q <= (rden_c == '0) ? 2'd1 : 2'd0;
      end

      if (div_ld) begin
        div_rem_q <= ld_num_abs;
        div_den_q <= ld_den_sh;
        div_q_q   <= '0;
        div_neg_q <= ld_num[IW-1] ^ ld_den[IW-1];
        div_ovf_q <= ld_ovf;
      end else if (iter_div) begin
        if (div_sub) div_rem_q <= div_rem_q - div_den_q;
        div_den_q <= div_den_q >> 1;
        div_q_q   <= q_nx;
      end

      // R stays 0 on error so the x/y terms remain in range
      if (state_q == S_DIV_R && last && err_q == 2'd0) begin
        if (div_ovf_q || div_out[IW-1] || div_out == '0) err_q <= 2'd2;
        else                                            r_q   <= div_out;
      end
      if (state_q == S_CALC_XY) ynum_q <= ynum_c;
      if (state_q == S_DIV_X && last) x_q <= div_out;

`ifdef CAL_POS_Z_EN
      if (state_q == S_DIV_Y && last) y_q <= div_out;
      if (state_q == S_ZSQ) begin
        if (zsq_c[IW-1] && err_q == 2'd0) err_q <= 2'd3;
        sq_val_q <= zsq_c[IW-1] ? '0 : zsq_c;
        sq_res_q <= '0;
        sq_bit_q <= POS_W'(1) << (POS_W-1);
      end
      if (state_q == S_SQRT) begin
        sq_res_q <= sq_res_nx;
        sq_bit_q <= sq_bit_q >> 1;
      end
`endif

      if (state_d == S_DONE) begin
        err <= err_q;
        if (err_q == 2'd1 || err_q == 2'd2) begin
          x_position <= '0;
          y_position <= '0;
          z_position <= '0;
        end else begin
          x_position <= POS_W'(x_q);
          y_position <= POS_W'(y_fin);
          z_position <= (err_q == 2'd0) ? z_fin : '0;
        end
      end
    end
  end

endmodule

// File: doc/cal_position_seq.md
# cal_position_seq

Sequential, parametrised successor to the combinational acoustic-source locator. It takes time-difference-of-arrival delays from a 4-microphone square array and computes the source position (x, y, z) in mm. A single shared iterative divider and an iterative square root are run under an FSM with a start/busy/done handshake, fixed latency and an error code. It sits between the cross-correlation delay estimators and the display/pan-tilt logic.

## Interface
- `DELAY_W`, default 8: delay input width, signed two's complement, unit = 1 sample tick.
- `POS_W`, default 16: output width, signed. Also sets divider and sqrt iteration count.
- `VEL`, default 34: sound travel per tick in mm, unsigned integer.
- `L`, default 100: microphone spacing in mm. Legal range 1 ≤ L < 2^(POS_W-2).
- Legality constraint: VEL·2^(DELAY_W-1) < 2^(POS_W-1).
- `fast_clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ena`  in  1: start request; accepted only in IDLE.
- `delay12`, `delay13`, `delay14`  in  DELAY_W each: signed arrival delay of mics 2/3/4 relative to mic 1; positive means later. Sampled on the accepting cycle.
- `busy`  out  1: high in every non-IDLE state.
- `cal_end`  out  1: one-cycle pulse; results are valid in that cycle.
- `x_position`, `y_position`, `z_position`  out  POS_W each: signed mm; held until the next `cal_end`.
- `err`  out  2 bits, valid with `cal_end`:
  - 0 = ok
  - 1 = degenerate (denominator is 0)
  - 2 = R ≤ 0 or R overflows POS_W
  - 3 = source below the array plane (z² < 0)

## Operation
- Geometry: M1 (0,0), M2 (L,0), M3 (L,L), M4 (0,L), all at z = 0. Mic i receives the sound at distance R + d_i, with d_i = VEL·delay1i (signed).
- Equations:
  - R = (d2² + d4² − d3²) / (2·(d3 − d2 − d4))
  - x = (L² − 2R·d2 − d2²) / (2L)
  - y = (L² − 2R·d4 − d4²) / (2L)
  - z = floor(sqrt(R² − x² − y²))
- Internal arithmetic: signed, width 2·POS_W+4. No intermediate overflow is permitted.
- Division: truncates toward zero.
  - Overflow pre-check: |num| ≥ |den|·2^(POS_W-1) means overflow.
  - On x/y overflow, saturate to ±(2^(POS_W-1)−1).
  - On R overflow, set err = 2.
- FSM states and durations:
  - IDLE: waits for `ena`.
  - LOAD, 1 cycle: register delays; form d_i, R numerator and R denominator.
  - DIV_R, POS_W cycles.
  - CALC_XY, 1 cycle.
  - DIV_X, POS_W cycles.
  - DIV_Y, POS_W cycles.
  - ZSQ, 1 cycle.
  - SQRT, POS_W cycles.
  - DONE, 1 cycle, `cal_end` = 1, then returns to IDLE.
- Latency is fixed regardless of error. On err 1 or 2, x, y and z are output as 0.
- On err 3, x and y are output as computed and z = 0.
- `ena` is ignored in every state except IDLE. Input changes while `busy` is high have no effect.

## Timing
- Reset: state = IDLE and all outputs = 0 (including `busy`, `cal_end`, `err`) on the first edge with `rst` = 1.
  - Reset mid-run aborts the run; no `cal_end` is produced.
  - Reset has priority over `ena` in the same cycle.
- `ena` high in IDLE at cycle 0:
  - LOAD in cycle 1.
  - `cal_end` in cycle 4·POS_W+4 (68 at default).
- Outputs and `err` are registered on the edge entering DONE.
- With `ena` held high, the next run starts from the IDLE cycle after DONE, giving a period of 4·POS_W+5 cycles.

## Configuration
- `CAL_POS_Z_EN`:
  - Defined: the ZSQ and SQRT states and the sqrt datapath exist. Latency is 4·POS_W+4; err 3 is possible.
  - Undefined: ZSQ and SQRT are removed, `z_position` is tied to 0 and err 3 never occurs. DONE follows DIV_Y, giving latency 3·POS_W+3 (51 at default).

## Test plan
1. VEL=1, L=100, `CAL_POS_Z_EN` defined; delays 20/38/20 → at cycle 68: x=15, y=15, z=159, err=0; `busy` high in cycles 1–68.
2. VEL=34, L=100; delays 0/0/0 → err=1, x=y=z=0, `cal_end` at cycle 68.
3. VEL=34; delays 0/1/0 (R=−17) → err=2, outputs 0.
4. VEL=1; delays 0/−34/0 (R=17) → x=50, y=50, z=0, err=3.
5. Pulse `ena` at cycles 0 and 10 with different delays → exactly one `cal_end` (cycle 68), carrying the cycle-0 result. Then assert `rst` in cycle 20 of a new run → `busy`=0 and outputs 0 next cycle, with no `cal_end`.
6. `CAL_POS_Z_EN` undefined, vector from scenario 1 → `cal_end` at cycle 51 with x=15, y=15, z=0, err=0. `ena` held high → successive `cal_end` pulses 52 cycles apart.
